// File: rtl/lock_sequencer.sv
// lock_sequencer: canal-lock trip controller. Arbitrates up/down boat requests and
// sequences valves and gates, scheduling the shared countdown timer for each timed phase.
module lock_sequencer #(
  parameter logic [9:0] T_FILL    = 10'd420,
  parameter logic [9:0] T_DRAIN   = 10'd480,
  parameter logic [9:0] T_TRANSIT = 10'd300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_up,
  input  logic       req_down,
  input  logic       timer_done,
  output logic [9:0] timer_seconds,
  output logic       timer_start,
  output logic       grant_up,
  output logic       grant_down,
  output logic       gate_low_open,
  output logic       gate_high_open,
  output logic       valve_fill,
  output logic       valve_drain,
  output logic       level_high,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PREP, ENTER, MOVE, EXIT} state_t;

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic       level_q, level_d;
  logic       last_up_q, last_up_d;
  logic       first_q, first_d;
  logic       grant_up_q, grant_up_d;
  logic       grant_down_q, grant_down_d;
  logic       pick_up;
  logic [9:0] secs_q, secs_d;
  logic       gate_low_q, gate_low_d;
  logic       gate_high_q, gate_high_d;
  logic       fill_q, fill_d;
  logic       drain_q, drain_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      level_q      <= 1'b0;
      last_up_q    <= 1'b0;
      first_q      <= 1'b0;
      grant_up_q   <= 1'b0;
      grant_down_q <= 1'b0;
      secs_q       <= '0;
      gate_low_q   <= 1'b0;
      gate_high_q  <= 1'b0;
      fill_q       <= 1'b0;
      drain_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      level_q      <= level_d;
      last_up_q    <= last_up_d;
      first_q      <= first_d;
      grant_up_q   <= grant_up_d;
      grant_down_q <= grant_down_d;
      secs_q       <= secs_d;
      gate_low_q   <= gate_low_d;
      gate_high_q  <= gate_high_d;
      fill_q       <= fill_d;
      drain_q      <= drain_d;
    end
  end

  // The first cycle of a timed state still sees the previous phase's expiry, so it is skipped.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    level_d      = level_q;
    last_up_d    = last_up_q;
    first_d      = 1'b0;
    grant_up_d   = 1'b0;
    grant_down_d = 1'b0;
    pick_up      = req_up && (!req_down || !last_up_q);
    case (state_q)
      IDLE: begin
        if (req_up || req_down) begin
          dir_d        = pick_up;
          last_up_d    = pick_up;
          grant_up_d   = pick_up;
          grant_down_d = !pick_up;
          first_d      = 1'b1;
          state_d      = (level_q == pick_up) ? PREP : ENTER;
        end
      end
      PREP: begin
        if (!first_q && timer_done) begin
          state_d = ENTER;
          level_d = !dir_q;
          first_d = 1'b1;
        end
      end
      ENTER: begin
        if (!first_q && timer_done) begin
          state_d = MOVE;
          first_d = 1'b1;
        end
      end
      MOVE: begin
        if (!first_q && timer_done) begin
          state_d = EXIT;
          level_d = dir_q;
          first_d = 1'b1;
        end
      end
      EXIT: begin
        if (!first_q && timer_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate/valve/duration outputs are decoded from the next state and registered, so they never glitch.
  always_comb begin
    secs_d      = '0;
    gate_low_d  = 1'b0;
    gate_high_d = 1'b0;
    fill_d      = 1'b0;
    drain_d     = 1'b0;
    case (state_d)
      PREP: begin
        if (dir_d) begin
          secs_d  = T_DRAIN;
          drain_d = 1'b1;
        end else begin
          secs_d = T_FILL;
          fill_d = 1'b1;
        end
      end
      ENTER: begin
        secs_d      = T_TRANSIT;
        gate_low_d  = dir_d;
        gate_high_d = !dir_d;
      end
      MOVE: begin
        if (dir_d) begin
          secs_d = T_FILL;
          fill_d = 1'b1;
        end else begin
          secs_d  = T_DRAIN;
          drain_d = 1'b1;
        end
      end
      EXIT: begin
        secs_d      = T_TRANSIT;
        gate_high_d = dir_d;
        gate_low_d  = !dir_d;
      end
      default: ;
    endcase
  end

  assign timer_seconds  = secs_q;
  assign timer_start    = first_q;
  assign grant_up       = grant_up_q;
  assign grant_down     = grant_down_q;
  assign gate_low_open  = gate_low_q;
  assign gate_high_open = gate_high_q;
  assign valve_fill     = fill_q;
  assign valve_drain    = drain_q;
  assign level_high     = level_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed trips through two lock_sequencer instances (T_TRANSIT=2 and 0),
// each driving a behavioural 1 Hz countdown timer.
module tb_lock_sequencer;

  typedef logic [28:0] psig_t;  // {len[11:0], outs{gl,gh,vf,vd}, secs[9:0], start, grants[1:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic req_up = 1'b0, req_down = 1'b0, zreq_up = 1'b0, zreq_down = 1'b0;
  logic sel = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [9:0] tsec, ztsec, tcnt = '0, ztcnt = '0;
  logic tstart, gu, gd, gl, gh, vf, vd, lvl, bsy;
  logic ztstart, zgu, zgd, zgl, zgh, zvf, zvd, zlvl, zbsy;
  wire  tdone  = (tcnt == 10'd0);
  wire  ztdone = (ztcnt == 10'd0);

  always @(posedge clk) begin
    if (tstart) tcnt <= tsec;
    else if (tcnt != 10'd0) tcnt <= tcnt - 10'd1;
    if (ztstart) ztcnt <= ztsec;
    else if (ztcnt != 10'd0) ztcnt <= ztcnt - 10'd1;
  end

  lock_sequencer #(.T_FILL(10'd3), .T_DRAIN(10'd4), .T_TRANSIT(10'd2)) u_dut (
    .clk(clk), .reset(reset), .req_up(req_up), .req_down(req_down), .timer_done(tdone),
    .timer_seconds(tsec), .timer_start(tstart), .grant_up(gu), .grant_down(gd),
    .gate_low_open(gl), .gate_high_open(gh), .valve_fill(vf), .valve_drain(vd),
    .level_high(lvl), .busy(bsy));

  lock_sequencer #(.T_FILL(10'd3), .T_DRAIN(10'd4), .T_TRANSIT(10'd0)) u_dut_z (
    .clk(clk), .reset(reset), .req_up(zreq_up), .req_down(zreq_down), .timer_done(ztdone),
    .timer_seconds(ztsec), .timer_start(ztstart), .grant_up(zgu), .grant_down(zgd),
    .gate_low_open(zgl), .gate_high_open(zgh), .valve_fill(zvf), .valve_drain(zvd),
    .level_high(zlvl), .busy(zbsy));

  wire [3:0] obs_outs   = sel ? {zgl, zgh, zvf, zvd} : {gl, gh, vf, vd};
  wire [9:0] obs_tsec   = sel ? ztsec : tsec;
  wire       obs_tstart = sel ? ztstart : tstart;
  wire       obs_gu     = sel ? zgu : gu;
  wire       obs_gd     = sel ? zgd : gd;
  wire       obs_busy   = sel ? zbsy : bsy;

  // Mutual exclusion of gates and valves, checked every cycle on both instances.
  always @(negedge clk) begin
    if (reset) begin
      vectors++;
      if ((gl && gh) || (vf && vd) || ((gl || gh) && (vf || vd))) begin
        miscompares++;
        $display("FAIL invariant_main: gates=%b%b valves=%b%b, required exclusive", gl, gh, vf, vd);
      end
      vectors++;
      if ((zgl && zgh) || (zvf && zvd) || ((zgl || zgh) && (zvf || zvd))) begin
        miscompares++;
        $display("FAIL invariant_zero: gates=%b%b valves=%b%b, required exclusive", zgl, zgh, zvf, zvd);
      end
    end
  end

  function automatic psig_t mk(int len, logic [3:0] o, int secs, logic st, int g);
    return {len[11:0], o, secs[9:0], st, g[1:0]};
  endfunction

  function automatic string fmt(psig_t s);
    return $sformatf("len=%0d outs=%b secs=%0d start=%b grants=%0d",
                     s[28:17], s[16:13], s[12:3], s[2], s[1:0]);
  endfunction

  // Called at the first-cycle negedge of a phase; returns at the first-cycle negedge of the next.
  task automatic measure(output psig_t s);
    int len;
    int g;
    logic [3:0] o0;
    logic [9:0] sec0;
    logic st0;
    len = 0; g = 0; o0 = obs_outs; sec0 = obs_tsec; st0 = obs_tstart;
    do begin
      g += int'(obs_gu) + int'(obs_gd);
      len++;
      @(negedge clk);
    end while (obs_busy && !obs_tstart && obs_outs == o0 && len < 2000);
    s = mk(len, o0, int'(sec0), st0, g);
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({tsec, tstart, gu, gd, gl, gh, vf, vd, lvl, bsy} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_main: outputs=%b, required all 0", {tsec, tstart, gu, gd, gl, gh, vf, vd, lvl, bsy});
    end
    vectors++;
    if ({ztsec, ztstart, zgu, zgd, zgl, zgh, zvf, zvd, zlvl, zbsy} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_zero: outputs=%b, required all 0", {ztsec, ztstart, zgu, zgd, zgl, zgh, zvf, zvd, zlvl, zbsy});
    end
    reset = 1'b1;
  endtask

  task automatic test_up_trip();
    psig_t s;
    psig_t e[3];
    e = '{mk(4, 4'b1000, 2, 1'b1, 1), mk(5, 4'b0010, 3, 1'b1, 0), mk(4, 4'b0100, 2, 1'b1, 0)};
    req_up = 1'b1;
    @(negedge clk);
    vectors++;
    if ({gu, gd} !== 2'b10) begin
      miscompares++;
      $display("FAIL up_grant: grant_up/down=%b, required 10", {gu, gd});
    end
    req_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      measure(s);
      vectors++;
      if (s !== e[i]) begin
        miscompares++;
        $display("FAIL up_phase%0d: got %s, required %s", i, fmt(s), fmt(e[i]));
      end
    end
    vectors++;
    if ({lvl, bsy, tsec} !== {1'b1, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL up_idle: level=%b busy=%b secs=%0d, required 1 0 0", lvl, bsy, tsec);
    end
  endtask

  task automatic test_down_trip();
    psig_t s;
    psig_t e[3];
    e = '{mk(4, 4'b0100, 2, 1'b1, 1), mk(6, 4'b0001, 4, 1'b1, 0), mk(4, 4'b1000, 2, 1'b1, 0)};
    req_down = 1'b1;
    @(negedge clk);
    vectors++;
    if ({gu, gd} !== 2'b01) begin
      miscompares++;
      $display("FAIL down_grant: grant_up/down=%b, required 01", {gu, gd});
    end
    req_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      measure(s);
      vectors++;
      if (s !== e[i]) begin
        miscompares++;
        $display("FAIL down_phase%0d: got %s, required %s", i, fmt(s), fmt(e[i]));
      end
    end
    vectors++;
    if ({lvl, bsy} !== 2'b00) begin
      miscompares++;
      $display("FAIL down_idle: level=%b busy=%b, required 0 0", lvl, bsy);
    end
  endtask

  task automatic test_prep_down();
    psig_t s;
    psig_t e[4];
    e = '{mk(5, 4'b0010, 3, 1'b1, 1), mk(4, 4'b0100, 2, 1'b1, 0),
          mk(6, 4'b0001, 4, 1'b1, 0), mk(4, 4'b1000, 2, 1'b1, 0)};
    req_down = 1'b1;
    @(negedge clk);
    req_down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      measure(s);
      vectors++;
      if (s !== e[i]) begin
        miscompares++;
        $display("FAIL prep_phase%0d: got %s, required %s", i, fmt(s), fmt(e[i]));
      end
      if (i == 0) begin
        vectors++;
        if (lvl !== 1'b1) begin
          miscompares++;
          $display("FAIL prep_level: level_high=%b after fill, required 1", lvl);
        end
      end
    end
    vectors++;
    if ({lvl, bsy} !== 2'b00) begin
      miscompares++;
      $display("FAIL prep_idle: level=%b busy=%b, required 0 0", lvl, bsy);
    end
  endtask

  task automatic test_back_to_back();
    psig_t s;
    logic [1:0] e[3];
    e = '{2'b10, 2'b01, 2'b10};
    reset = 1'b0;
    req_up = 1'b1;
    req_down = 1'b1;
    @(negedge clk) reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      vectors++;
      if ({gu, gd} !== e[t]) begin
        miscompares++;
        $display("FAIL rr_trip%0d: grant_up/down=%b, required %b", t, {gu, gd}, e[t]);
      end
      if (t == 2) begin
        req_up = 1'b0;
        req_down = 1'b0;
      end
      for (int p = 0; p < 3; p++) measure(s);
    end
  endtask

  task automatic test_reset_mid_move();
    psig_t s;
    pulse_reset();
    req_down = 1'b1;
    @(negedge clk);
    req_down = 1'b0;
    measure(s);
    measure(s);
    repeat (2) @(negedge clk);
    vectors++;
    if ({vd, lvl, bsy} !== 3'b111) begin
      miscompares++;
      $display("FAIL mid_move_pre: drain/level/busy=%b, required 111", {vd, lvl, bsy});
    end
    reset = 1'b0;
    req_down = 1'b1;
    #1;
    vectors++;
    if ({gl, gh, vf, vd, lvl, bsy, tstart, tsec} !== 17'd0) begin
      miscompares++;
      $display("FAIL async_abort: gates/valves/level/busy/start/secs=%b, required 0", {gl, gh, vf, vd, lvl, bsy, tstart, tsec});
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({gd, vf, tstart, tsec} !== {3'b111, 10'd3}) begin
      miscompares++;
      $display("FAIL restart_prep: grant_down/fill/start=%b secs=%0d, required 111 3", {gd, vf, tstart}, tsec);
    end
    req_down = 1'b0;
  endtask

  task automatic test_transit_zero();
    psig_t s;
    psig_t e[3];
    e = '{mk(2, 4'b1000, 0, 1'b1, 1), mk(5, 4'b0010, 3, 1'b1, 0), mk(2, 4'b0100, 0, 1'b1, 0)};
    pulse_reset();
    sel = 1'b1;
    zreq_up = 1'b1;
    @(negedge clk);
    vectors++;
    if ({zgu, zgd, ztdone} !== 3'b101) begin
      miscompares++;
      $display("FAIL zero_grant: grant_up/down/stale_done=%b, required 101", {zgu, zgd, ztdone});
    end
    zreq_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      measure(s);
      vectors++;
      if (s !== e[i]) begin
        miscompares++;
        $display("FAIL zero_phase%0d: got %s, required %s", i, fmt(s), fmt(e[i]));
      end
    end
    vectors++;
    if ({zlvl, zbsy} !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_idle: level=%b busy=%b, required 1 0", zlvl, zbsy);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_trip();
    test_down_trip();
    test_prep_down();
    test_back_to_back();
    test_reset_mid_move();
    test_transit_zero();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Canal-lock trip controller that schedules the shared 10-bit 1 Hz countdown timer.
- Accepts boat requests from the low side (going up) and the high side (going down), and arbitrates between them.
- Sequences the valves and gates through each trip. For every timed phase it loads a duration into the timer and pulses the timer's start input.
- Sits between the request/sensor inputs and the timer instance, and drives the gate, valve and status outputs.

Parameters:
T_FILL, 420, seconds to fill the chamber (low to high level); 10-bit, 0..1023
T_DRAIN, 480, seconds to drain the chamber (high to low level); 10-bit, 0..1023
T_TRANSIT, 300, seconds a gate is held open for boat entry or exit; 10-bit, 0..1023

Ports:
clk  input  1  system clock (1 Hz in the lab build; any rate in simulation)
reset  input  1  asynchronous, active-low reset
req_up  input  1  boat waiting at low gate; level-sensitive; held until grant_up
req_down  input  1  boat waiting at high gate; level-sensitive; held until grant_down
timer_done  input  1  timer expired flag (high while timer count == 0)
timer_seconds  output  10  duration presented to the timer load input
timer_start  output  1  one-cycle pulse; the timer loads timer_seconds at this edge
grant_up  output  1  one-cycle pulse: up trip accepted
grant_down  output  1  one-cycle pulse: down trip accepted
gate_low_open  output  1  low gate open
gate_high_open  output  1  high gate open
valve_fill  output  1  fill valve open
valve_drain  output  1  drain valve open
level_high  output  1  chamber water level: 1 = high, 0 = low
busy  output  1  trip in progress (state != IDLE)

Behaviour:
- States: IDLE, PREP, ENTER, MOVE, EXIT. A direction register dir tracks the trip (1 = up).
- Reset (asynchronous, active-low):
  - State IDLE, dir = 0, level_high = 0, last-served direction = down (so up wins the first tie).
  - All outputs 0.
  - A reset mid-trip aborts immediately: gates closed, valves closed, level_high = 0.
- Arbitration is evaluated only in IDLE:
  - One request high: grant that request.
  - Both high: grant the direction opposite the last served (round-robin).
  - On the grant edge: the grant pulse is high for 1 cycle, dir is latched, and last-served is updated.
  - Requests outside IDLE are ignored; they are not queued beyond the held level.
- Next state from IDLE:
  - PREP if level_high does not match the entry side (up trip needs level low; down trip needs level high).
  - Otherwise ENTER.
- Phase actions:
  - PREP (up): drain, T_DRAIN, valve_drain = 1.
  - PREP (down): fill, T_FILL, valve_fill = 1.
  - ENTER (up): gate_low_open = 1, T_TRANSIT.
  - ENTER (down): gate_high_open = 1, T_TRANSIT.
  - MOVE (up): fill, T_FILL, valve_fill = 1.
  - MOVE (down): drain, T_DRAIN, valve_drain = 1.
  - EXIT (up): gate_high_open = 1, T_TRANSIT.
  - EXIT (down): gate_low_open = 1, T_TRANSIT.
- Transitions: PREP -> ENTER -> MOVE -> EXIT -> IDLE. At the end of PREP and at the end of MOVE, level_high is updated to the new level.
- Timed-state protocol:
  - timer_start is high exactly in the first cycle of each timed state.
  - timer_seconds holds the phase duration for the whole state; it is 0 in IDLE.
  - timer_done is ignored in the first cycle of a state, because the stale expiry from the previous phase is still visible.
  - From the second cycle on, timer_done = 1 advances the state at that edge.
  - With the timer's load-at-start behaviour, a state of duration N lasts exactly N+2 cycles. N = 0 gives 2 cycles.
- Safety invariants, every cycle:
  - Never both gates open.
  - Never both valves open.
  - Never a gate and a valve open together.
  - All of these are Moore-decoded from state and dir and are glitch-free (registered state).
- Immediate re-request: the next trip is granted at the first IDLE edge, so IDLE lasts 1 cycle minimum.

Test Plan:
- Params T_FILL=3, T_DRAIN=4, T_TRANSIT=2; after reset, pulse req_up -> grant_up 1 cycle; no PREP; ENTER (gate_low_open) 4 cycles; MOVE (valve_fill) 5 cycles; EXIT (gate_high_open) 4 cycles; then IDLE with level_high = 1, busy = 0.
- Next, req_down -> PREP skipped (level already high); ENTER high gate 4, MOVE drain 6, EXIT low gate 4; level_high = 0.
- From level low, req_down -> PREP fill 5 cycles, level_high = 1; then ENTER, MOVE drain, EXIT as above; timer_start seen exactly 4 times, with timer_seconds 3, 2, 4, 2.
- req_up and req_down both high in IDLE after reset -> grant_up first; keep both high -> next trip grant_down; then grant_up again (alternation).
- Assert reset low mid-MOVE -> same cycle (async): state IDLE, all gates and valves 0, level_high 0, busy 0; releasing reset with req_down high -> PREP fill begins.
- Edge cases: set T_TRANSIT=0 -> ENTER/EXIT last 2 cycles each; hold timer_done = 1 in a state's first cycle -> no advance; throughout all runs, assert the gate/valve mutual-exclusion invariants.
